epcs_rope_reader: RTL and testbench

Sequencer that fetches 16-bit fixed-memory (core rope) words for the FPGA AGC from the DE0-Nano EPCS serial configuration flash. It owns EPCS_CSN/EPCS_DCLK/EPCS_ASDI/EPCS_DATA and accepts one word request at a time from the rope interface. For each request it issues the EPCS READ command (0x03) with a 24-bit byte address and returns the word with a one-cycle valid pulse. It runs in the SIM_CLK domain (51.2 MHz PLL output).

---
 rtl/epcs_rope_reader.sv | 193 +++++++++++++++++++
 tb/tb_epcs_rope_reader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/epcs_rope_reader.sv
// epcs_rope_reader
// Fetches 16-bit core-rope words for the AGC from the EPCS serial configuration
// flash. It uses the READ command (0x03), a 24-bit byte address and SPI mode 0.
// Only one request is in flight at a time.
//
// Ports:
//   SIM_CLK, SIM_RST_n  - clock; asynchronous active-low reset
//   RD_REQ, RD_ADDR     - word request, accepted when RD_REQ=1 and BUSY=0
//   RD_DATA, RD_VALID   - fetched word, with a one-cycle valid pulse
//   BUSY                - 1 when a request would not be accepted this cycle
//   EPCS_CSN/DCLK/ASDI  - flash chip select, serial clock, command/address out
//   EPCS_DATA           - flash serial data in
//
// Optional feature, macro EPCS_STREAM_EN:
//   After a word is returned, chip select is held low in HOLD for up to
//   HOLD_CYCLES. A request for the next word continues the open READ and skips
//   the command and address phases.
module epcs_rope_reader #(
    parameter int          CLK_DIV     = 2,
    parameter logic [23:0] BASE_ADDR   = 24'h100000,
    parameter int          CS_GAP      = 6,
    parameter int          HOLD_CYCLES = 64
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST_n,
    input  logic        RD_REQ,
    input  logic [15:0] RD_ADDR,
    output logic [15:0] RD_DATA,
    output logic        RD_VALID,
    output logic        BUSY,
    output logic        EPCS_CSN,
    output logic        EPCS_DCLK,
    output logic        EPCS_ASDI,
    input  logic        EPCS_DATA
);

    // One counter serves both the CS gap and the hold timeout.
    localparam int CNT_MAX = (HOLD_CYCLES > CS_GAP) ? HOLD_CYCLES : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIV_W   = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {
        S_GAP, S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE, S_HOLD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic [31:0]      tx_sr;     // {command, byte address}, MSB on ASDI
    logic [15:0]      rx_sr;
    logic [23:0]      req_byte_addr;
    logic             half_end;
`ifdef EPCS_STREAM_EN
    logic [15:0]      last_addr;
    logic             pending;   // accepted in HOLD, waiting for CS gap to finish
`endif

    assign req_byte_addr = BASE_ADDR + {7'b0, RD_ADDR, 1'b0};
    assign half_end      = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            state     <= S_GAP;
            cnt       <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            RD_DATA   <= '0;
            RD_VALID  <= 1'b0;
            BUSY      <= 1'b1;
            EPCS_CSN  <= 1'b1;
            EPCS_DCLK <= 1'b0;
            EPCS_ASDI <= 1'b0;
`ifdef EPCS_STREAM_EN
            last_addr <= '0;
            pending   <= 1'b0;
`endif
        end else begin
            case (state)
                S_GAP: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(CS_GAP - 1)) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
`ifdef EPCS_STREAM_EN
                        if (pending) begin
                            pending   <= 1'b0;
                            state     <= S_CMD;
                            BUSY      <= 1'b1;
                            EPCS_CSN  <= 1'b0;
                            EPCS_ASDI <= tx_sr[31];
                            div_cnt   <= '0;
                            bit_cnt   <= '0;
                        end
`endif
                    end
                end
                S_IDLE: begin
                    if (RD_REQ) begin
                        tx_sr     <= {8'h03, req_byte_addr};
                        state     <= S_CMD;
                        BUSY      <= 1'b1;
                        EPCS_CSN  <= 1'b0;
                        EPCS_ASDI <= 1'b0;   // MSB of 0x03
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
`ifdef EPCS_STREAM_EN
                        last_addr <= RD_ADDR;
`endif
                    end
                end
                S_CMD, S_ADDR, S_DATA: begin
                    div_cnt <= div_cnt + DIV_W'(1);
                    if (half_end) begin
                        div_cnt   <= '0;
                        EPCS_DCLK <= ~EPCS_DCLK;
                        if (!EPCS_DCLK) begin
                            // rising DCLK edge: sample flash output
                            if (state == S_DATA) rx_sr <= {rx_sr[14:0], EPCS_DATA};
                        end else begin
                            // falling DCLK edge closes the bit; next ASDI bit goes out
                            bit_cnt   <= bit_cnt + 5'd1;
                            tx_sr     <= {tx_sr[30:0], 1'b0};
                            EPCS_ASDI <= tx_sr[30];
                            if (state == S_CMD && bit_cnt == 5'd7) begin
                                state   <= S_ADDR;
                                bit_cnt <= '0;
                            end
                            if (state == S_ADDR && bit_cnt == 5'd23) begin
                                state     <= S_DATA;
                                bit_cnt   <= '0;
                                EPCS_ASDI <= 1'b0;
                            end
                            if (state == S_DATA && bit_cnt == 5'd15) begin
                                state    <= S_DONE;
                                RD_VALID <= 1'b1;
                                RD_DATA  <= rx_sr;
                            end
                        end
                    end
                end
                S_DONE: begin
                    RD_VALID <= 1'b0;
                    cnt      <= '0;
`ifdef EPCS_STREAM_EN
                    state    <= S_HOLD;
                    BUSY     <= 1'b0;
`else
                    state    <= S_GAP;
                    EPCS_CSN <= 1'b1;
`endif
                end
`ifdef EPCS_STREAM_EN
                S_HOLD: begin
                    cnt <= cnt + CNT_W'(1);
                    // a request in the timeout cycle takes priority over the timeout
                    if (RD_REQ) begin
                        BUSY      <= 1'b1;
                        cnt       <= '0;
                        last_addr <= RD_ADDR;
                        if (last_addr != 16'hFFFF && RD_ADDR == last_addr + 16'd1) begin
                            // flash auto-increments, so just keep clocking data
                            state   <= S_DATA;
                            div_cnt <= '0;
                            bit_cnt <= '0;
                        end else begin
                            state    <= S_GAP;
                            EPCS_CSN <= 1'b1;
                            pending  <= 1'b1;
                            tx_sr    <= {8'h03, req_byte_addr};
                        end
                    end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        state    <= S_GAP;
                        EPCS_CSN <= 1'b1;
                        BUSY     <= 1'b1;
                        cnt      <= '0;
                    end
                end
`endif
                default: begin
                    state    <= S_GAP;
                    EPCS_CSN <= 1'b1;
                    BUSY     <= 1'b1;
                    cnt      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_epcs_rope_reader.sv
// Directed bench for epcs_rope_reader. It includes a behavioural EPCS flash
// model and a scoreboard of expected words and their valid cycles.
module tb_epcs_rope_reader;

    logic        SIM_CLK = 1'b0;
    logic        SIM_RST_n = 1'b0;
    logic        RD_REQ = 1'b0;
    logic [15:0] RD_ADDR = '0;
    logic [15:0] RD_DATA;
    logic        RD_VALID;
    logic        BUSY;
    logic        EPCS_CSN;
    logic        EPCS_DCLK;
    logic        EPCS_ASDI;
    logic        EPCS_DATA = 1'b0;

    epcs_rope_reader dut (
        .SIM_CLK(SIM_CLK), .SIM_RST_n(SIM_RST_n), .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR),
        .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .BUSY(BUSY),
        .EPCS_CSN(EPCS_CSN), .EPCS_DCLK(EPCS_DCLK), .EPCS_ASDI(EPCS_ASDI),
        .EPCS_DATA(EPCS_DATA)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- flash model ----------------
    logic [7:0] mem [int];

    function automatic logic [7:0] byte_at(input logic [23:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [15:0] exp_word(input logic [15:0] a);
        logic [23:0] b;
        b = 24'h100000 + {7'b0, a, 1'b0};
        return {byte_at(b), byte_at(b + 24'd1)};
    endfunction

    int          bitn = 0;
    bit          dclk_q = 1'b0;
    logic [31:0] in_sr = '0;
    logic [7:0]  cmd_rx = '0;
    logic [23:0] addr_rx = '0;

    always @(EPCS_CSN, EPCS_DCLK) begin
        int k;
        logic [7:0] b;
        if (EPCS_CSN !== 1'b0) begin
            bitn = 0;
        end else if (EPCS_DCLK === 1'b1 && !dclk_q) begin
            if (bitn < 32) in_sr = {in_sr[30:0], EPCS_ASDI};
            bitn++;
            if (bitn == 32) begin
                cmd_rx  = in_sr[31:24];
                addr_rx = in_sr[23:0];
            end
        end else if (EPCS_DCLK === 1'b0 && dclk_q && bitn >= 32) begin
            k = bitn - 32;
            b = byte_at(addr_rx + 24'(k / 8));
            EPCS_DATA = b[7 - (k % 8)];
        end
        dclk_q = (EPCS_DCLK === 1'b1);
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [15:0] data;
        int          t;
    } sb_t;

    sb_t sb_q[$];
    sb_t push_e;
    sb_t pop_e;
    int  cyc = 0;
    int  exp_lat = 193;
    int  acc_n = 0;
    int  acc_t_prev = 0;
    int  acc_t_last = 0;
    int  val_n = 0;
    int  csn_fall = 0;
    int  csn_rise = 0;
    logic csn_q = 1'b1;

    always @(posedge SIM_CLK) begin
        cyc <= cyc + 1;
        if (SIM_RST_n && RD_REQ && !BUSY) begin
            push_e.data = exp_word(RD_ADDR);
            push_e.t    = cyc + exp_lat;
            sb_q.push_back(push_e);
            acc_n++;
            acc_t_prev = acc_t_last;
            acc_t_last = cyc;
        end
    end

    always @(negedge SIM_CLK) begin
        if (RD_VALID === 1'b1) begin
            val_n++;
            chk("valid_with_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                pop_e = sb_q.pop_front();
                chk("rd_data", 32'(RD_DATA), 32'(pop_e.data));
                chk("valid_cycle", cyc, pop_e.t);
            end
        end
        if (csn_q === 1'b1 && EPCS_CSN === 1'b0) csn_fall++;
        if (csn_q === 1'b0 && EPCS_CSN === 1'b1) csn_rise++;
        csn_q = EPCS_CSN;
    end

    task automatic do_read(input logic [15:0] a, input int lat);
        int n;
        exp_lat = lat;
        RD_ADDR = a;
        RD_REQ  = 1'b1;
        n = 0;
        while (BUSY && n < 1000) begin
            @(negedge SIM_CLK);
            n++;
        end
        chk("accept_wait", 32'(n < 1000), 32'd1);
        @(negedge SIM_CLK);
        RD_REQ = 1'b0;
        n = 0;
        while (!RD_VALID && n < lat + 50) begin
            @(negedge SIM_CLK);
            n++;
        end
        chk("valid_wait", 32'(n < lat + 50), 32'd1);
    endtask

    initial begin
        int n, v0, a0, f0, r0, busy_low;
        mem[32'h100000] = 8'hA5;
        mem[32'h100001] = 8'hC3;
        mem[32'h10FFFE] = 8'h12;
        mem[32'h10FFFF] = 8'h34;

        // reset values
        @(negedge SIM_CLK);
        chk("rst_csn", 32'(EPCS_CSN), 32'd1);
        chk("rst_dclk", 32'(EPCS_DCLK), 32'd0);
        chk("rst_asdi", 32'(EPCS_ASDI), 32'd0);
        chk("rst_rd_data", 32'(RD_DATA), 32'd0);
        chk("rst_rd_valid", 32'(RD_VALID), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd1);
        @(negedge SIM_CLK);
        SIM_RST_n = 1'b1;

        // word 0
        do_read(16'h0000, 193);
        chk("w0_data", 32'(RD_DATA), 32'h0000A5C3);
        chk("w0_cmd", 32'(cmd_rx), 32'h03);
        chk("w0_addr", 32'(addr_rx), 32'h100000);
`ifndef EPCS_STREAM_EN
        for (int i = 0; i < 6; i++) begin
            @(negedge SIM_CLK);
            chk("w0_gap_csn", 32'(EPCS_CSN), 32'd1);
        end
`endif
        repeat (80) @(negedge SIM_CLK);

        // top of the word space
        do_read(16'h7FFF, 193);
        chk("w7fff_data", 32'(RD_DATA), 32'h00001234);
        chk("w7fff_addr", 32'(addr_rx), 32'h10FFFE);
        repeat (80) @(negedge SIM_CLK);

`ifndef EPCS_STREAM_EN
        // request held high across two transactions
        v0 = val_n; a0 = acc_n; busy_low = 0; n = 0;
        exp_lat = 193;
        RD_ADDR = 16'h0003;
        RD_REQ  = 1'b1;
        while ((val_n - v0) < 2 && n < 600) begin
            if (!BUSY) busy_low++;
            @(negedge SIM_CLK);
            n++;
        end
        RD_REQ = 1'b0;
        chk("held_valids", 32'(val_n - v0), 32'd2);
        chk("held_accepts", 32'(acc_n - a0), 32'd2);
        chk("held_spacing", 32'(acc_t_last - acc_t_prev), 32'd200);
        chk("held_busy_low", 32'(busy_low), 32'd2);
        repeat (20) @(negedge SIM_CLK);
`endif

        // reset in the middle of the address phase
        exp_lat = 193;
        RD_ADDR = 16'h0001;
        RD_REQ  = 1'b1;
        n = 0;
        while (BUSY && n < 1000) begin
            @(negedge SIM_CLK);
            n++;
        end
        @(negedge SIM_CLK);
        RD_REQ = 1'b0;
        repeat (50) @(negedge SIM_CLK);
        v0 = val_n;
        SIM_RST_n = 1'b0;
        sb_q.delete();
        #1;
        chk("abort_csn", 32'(EPCS_CSN), 32'd1);
        chk("abort_dclk", 32'(EPCS_DCLK), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd1);
        repeat (3) @(negedge SIM_CLK);
        SIM_RST_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge SIM_CLK);
            chk("post_rst_gap_busy", 32'(BUSY), 32'd1);
        end
        repeat (200) @(negedge SIM_CLK);
        chk("abort_no_valid", 32'(val_n - v0), 32'd0);
        do_read(16'h0002, 193);
        chk("post_rst_addr", 32'(addr_rx), 32'h100004);
        repeat (80) @(negedge SIM_CLK);

`ifdef EPCS_STREAM_EN
        do_read(16'h0005, 193);
        f0 = csn_fall;
        do_read(16'h0006, 65);
        chk("stream_no_cmd", 32'(csn_fall - f0), 32'd0);
        do_read(16'h0006, 199);
        chk("stream_refetch_cs", 32'(csn_fall - f0), 32'd1);
        chk("stream_refetch_cmd", 32'(cmd_rx), 32'h03);
        chk("stream_refetch_addr", 32'(addr_rx), 32'h10000C);
        repeat (63) @(negedge SIM_CLK);
        chk("hold_csn_low", 32'(EPCS_CSN), 32'd0);
        repeat (2) @(negedge SIM_CLK);
        chk("hold_timeout_csn", 32'(EPCS_CSN), 32'd1);
`else
        f0 = csn_fall;
        r0 = csn_rise;
        do_read(16'h0005, 193);
        chk("seq5_addr", 32'(addr_rx), 32'h10000A);
        do_read(16'h0006, 193);
        chk("seq6_cmd", 32'(cmd_rx), 32'h03);
        chk("seq6_addr", 32'(addr_rx), 32'h10000C);
        repeat (3) @(negedge SIM_CLK);
        chk("seq_csn_falls", 32'(csn_fall - f0), 32'd2);
        chk("seq_csn_rises", 32'(csn_rise - r0), 32'd2);
`endif
        repeat (10) @(negedge SIM_CLK);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
